// File: rtl/filter_out_buffer.sv
// -----------------------------------------------------------------------------
// filter_out_buffer
//   Output capture stage behind the DA FIR filter. A result word is captured
//   on each rising edge of the filter's ts strobe and queued in a small
//   first-word-fall-through FIFO. The FIFO head is presented on a valid/ready
//   stream. If the consumer stalls and the FIFO fills, further results are
//   dropped. A drop sets a sticky overflow flag and increments a saturating
//   drop counter.
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous active-low reset, highest priority
//   ts        in   result strobe; y_in is valid while ts=1
//   y_in      in   filter result, stored as raw bits
//   clr       in   synchronous clear of FIFO, overflow and drop counter
//   m_valid   out  stream data valid (FIFO not empty)
//   m_ready   in   consumer ready
//   m_data    out  stream data (FIFO head), zero when empty
//   level     out  number of words currently held
//   overflow  out  sticky flag, at least one result dropped
//   drop_cnt  out  dropped-result count, saturates at all-ones
//
// All outputs are registers. The head word for the next cycle is computed
// combinationally so that m_data still shows the FIFO head with one cycle of
// latency from push to m_valid.
// -----------------------------------------------------------------------------
module filter_out_buffer #(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ts,
    input  logic [WORD_WIDTH-1:0]         y_in,
    input  logic                          clr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WORD_WIDTH-1:0]         m_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [PW-1:0]         PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0]         PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]         LVL_ZERO  = {LW{1'b0}};
    localparam logic [LW-1:0]         LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]         LVL_FULL  = {1'b1, {PW{1'b0}}};
    localparam logic [WORD_WIDTH-1:0] DATA_ZERO = {WORD_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        logic [CNT_WIDTH-1:0] res;
        if (cnt == {CNT_WIDTH{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [WORD_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [LW-1:0]         level_r;
    logic                  ts_q_r;
    logic                  m_valid_r;
    logic [WORD_WIDTH-1:0] m_data_r;
    logic                  overflow_r;
    logic [CNT_WIDTH-1:0]  drop_cnt_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  write_s;
    logic                  drop_s;
    logic [PW-1:0]         wr_ptr_nxt_s;
    logic [PW-1:0]         rd_ptr_nxt_s;
    logic [LW-1:0]         level_nxt_s;
    logic [WORD_WIDTH-1:0] head_nxt_s;

    // Push/pop decode and next-state computation for pointers, level and head.
    always_comb begin
        push_s       = ts & ~ts_q_r;
        pop_s        = m_valid_r & m_ready;
        full_s       = (level_r == LVL_FULL);
        // A pop on a full FIFO frees a slot, so a simultaneous push is kept.
        write_s      = push_s & (~full_s | pop_s);
        drop_s       = push_s & full_s & ~pop_s;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        level_nxt_s  = level_r;
        head_nxt_s   = DATA_ZERO;

        if (write_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({write_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase

        // The word being written this cycle becomes the head when it lands
        // in the slot the read pointer moves to (empty FIFO, or last word
        // popped while a new one arrives).
        if (level_nxt_s == LVL_ZERO) begin
            head_nxt_s = DATA_ZERO;
        end else if (write_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = y_in;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (rst && !clr && write_s) begin
            mem_r[wr_ptr_r] <= y_in;
        end
    end

    // Control state, flags and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            ts_q_r     <= 1'b0;
            m_valid_r  <= 1'b0;
            m_data_r   <= DATA_ZERO;
            overflow_r <= 1'b0;
            drop_cnt_r <= CNT_ZERO;
        end else if (clr) begin
            // ts history keeps tracking so a ts held across clr is not recaptured.
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            ts_q_r     <= ts;
            m_valid_r  <= 1'b0;
            m_data_r   <= DATA_ZERO;
            overflow_r <= 1'b0;
            drop_cnt_r <= CNT_ZERO;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            level_r    <= level_nxt_s;
            ts_q_r     <= ts;
            m_valid_r  <= (level_nxt_s != LVL_ZERO);
            m_data_r   <= head_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
                overflow_r <= overflow_r;
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign level    = level_r;
    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

endmodule
